// File: rtl/mem_initiator.sv
// CPU-to-memory access initiator: one request per access, size/alignment
// checks, load extension. Define MEM_INITIATOR_TIMEOUT_EN to abort stalled accesses.
module mem_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_bhw,
  input  logic        cpu_sgn,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        request,
  output logic [2:0]  bhw,
  output logic        WR_nRD,
  output logic [31:0] ADR,
  output logic [31:0] DATA,
  input  logic [31:0] DATAOUT,
  input  logic        send
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        legal, expired, sgn, accept, capture;
  logic [31:0] rdata_q, rdata_ext;

  always_comb begin
    legal = 1'b0;
    case (cpu_bhw)
      3'b001:  legal = 1'b1;
      3'b010:  legal = ~cpu_adr[0];
      3'b100:  legal = (cpu_adr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

`ifdef MEM_INITIATOR_TIMEOUT_EN
  logic [7:0] cnt;
  assign expired = (cnt == 8'(TIMEOUT - 1));

  // Cleared while idle so every access starts its WAIT count from zero
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                cnt <= 8'd0;
    else if (state == S_IDLE) cnt <= 8'd0;
    else if (state == S_WAIT) cnt <= cnt + 8'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cpu_req) state_nxt = legal ? S_REQ : S_ERR;
      S_REQ:   state_nxt = send ? S_DONE : S_WAIT;
      S_WAIT:  begin
        if (send)         state_nxt = S_DONE;
        else if (expired) state_nxt = S_ERR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_ext = DATAOUT;
    case (bhw)
      3'b001:  rdata_ext = {{24{sgn & DATAOUT[7]}},  DATAOUT[7:0]};
      3'b010:  rdata_ext = {{16{sgn & DATAOUT[15]}}, DATAOUT[15:0]};
      default: rdata_ext = DATAOUT;
    endcase
  end

  assign accept  = (state == S_IDLE) && cpu_req && legal;
  assign capture = ((state == S_REQ) || (state == S_WAIT)) && send;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_IDLE;
      bhw     <= 3'b000;
      WR_nRD  <= 1'b0;
      ADR     <= 32'd0;
      DATA    <= 32'd0;
      sgn     <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bhw    <= cpu_bhw;
        WR_nRD <= cpu_wr;
        ADR    <= cpu_adr;
        DATA   <= cpu_wdata;
        sgn    <= cpu_sgn;
      end
      if (capture) rdata_q <= WR_nRD ? 32'd0 : rdata_ext;
    end
  end

  assign request   = (state == S_REQ);
  assign cpu_busy  = (state != S_IDLE);
  assign cpu_done  = (state == S_DONE);
  assign cpu_err   = (state == S_ERR);
  assign cpu_rdata = (state == S_DONE) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: inputs driven and outputs sampled on the falling edge.
module tb_mem_initiator;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        cpu_req, cpu_wr, cpu_sgn, send;
  logic [2:0]  cpu_bhw;
  logic [31:0] cpu_adr, cpu_wdata, DATAOUT;
  logic [31:0] cpu_rdata, ADR, DATA;
  logic        cpu_done, cpu_err, cpu_busy, request, WR_nRD;
  logic [2:0]  bhw;

  int errors = 0;
  int checks = 0;

  mem_initiator #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_bhw(cpu_bhw), .cpu_sgn(cpu_sgn),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .request(request), .bhw(bhw), .WR_nRD(WR_nRD), .ADR(ADR), .DATA(DATA),
    .DATAOUT(DATAOUT), .send(send)
  );

  always #5 CLK = ~CLK;

  // Present an access for exactly one rising edge; returns at the next falling edge.
  task automatic issue(input logic wr, input logic [2:0] sz, input logic sg,
                       input logic [31:0] adr, input logic [31:0] wd);
    cpu_req = 1'b1; cpu_wr = wr; cpu_bhw = sz; cpu_sgn = sg;
    cpu_adr = adr; cpu_wdata = wd;
    @(negedge CLK);
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_bhw = 3'b000; cpu_sgn = 1'b0;
    cpu_adr = '0; cpu_wdata = '0; DATAOUT = '0; send = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({request, cpu_busy, cpu_done, cpu_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0000", {request, cpu_busy, cpu_done, cpu_err});
    end
    checks++;
    if ({bhw, WR_nRD, ADR, DATA, cpu_rdata} !== '0) begin
      errors++; $display("FAIL reset_fields: got bhw=%b wr=%b adr=%h data=%h rdata=%h expected all zero",
                         bhw, WR_nRD, ADR, DATA, cpu_rdata);
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_word_load;
    issue(1'b0, 3'b100, 1'b0, 32'h10, 32'h0);
    checks++;
    if (request !== 1'b1 || cpu_busy !== 1'b1 || ADR !== 32'h10 || bhw !== 3'b100 || WR_nRD !== 1'b0) begin
      errors++; $display("FAIL wl_req: got req=%b busy=%b adr=%h bhw=%b wr=%b expected 1 1 00000010 100 0",
                         request, cpu_busy, ADR, bhw, WR_nRD);
    end
    @(negedge CLK);
    checks++;
    if (request !== 1'b0 || cpu_done !== 1'b0) begin
      errors++; $display("FAIL wl_wait: got req=%b done=%b expected 0 0", request, cpu_done);
    end
    send = 1'b1; DATAOUT = 32'hDEADBEEF;
    @(negedge CLK);
    send = 1'b0; DATAOUT = 32'h0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wl_done: got done=%b rdata=%h expected 1 deadbeef", cpu_done, cpu_rdata);
    end
    @(negedge CLK);
    checks++;
    if (cpu_done !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL wl_idle: got done=%b busy=%b rdata=%h expected 0 0 0", cpu_done, cpu_busy, cpu_rdata);
    end
  endtask

  // Response arrives while still in REQ, so the access completes without a WAIT cycle.
  task automatic test_load_extend;
    logic [31:0] dout [4] = '{32'h00000080, 32'h00000080, 32'h1234_8001, 32'hABCD_7FFF};
    logic [2:0]  sz   [4] = '{3'b001, 3'b001, 3'b010, 3'b010};
    logic        sg   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], sg[i], 32'h22, 32'h0);
      send = 1'b1; DATAOUT = dout[i];
      @(negedge CLK);
      send = 1'b0; DATAOUT = 32'h0;
      checks++;
      if (cpu_done !== 1'b1 || cpu_rdata !== exp[i]) begin
        errors++; $display("FAIL ext_%0d: got done=%b rdata=%h expected 1 %h", i, cpu_done, cpu_rdata, exp[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_illegal;
    logic [2:0]  sz  [4] = '{3'b010, 3'b100, 3'b011, 3'b000};
    logic [31:0] adr [4] = '{32'h3, 32'h2, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, sz[i], 1'b0, adr[i], 32'hFFFF);
      checks++;
      if (cpu_err !== 1'b1 || request !== 1'b0 || cpu_busy !== 1'b1 || cpu_rdata !== 32'h0) begin
        errors++; $display("FAIL illegal_%0d: got err=%b req=%b busy=%b rdata=%h expected 1 0 1 0",
                           i, cpu_err, request, cpu_busy, cpu_rdata);
      end
      @(negedge CLK);
      checks++;
      if (cpu_err !== 1'b0 || cpu_busy !== 1'b0) begin
        errors++; $display("FAIL illegal_end_%0d: got err=%b busy=%b expected 0 0", i, cpu_err, cpu_busy);
      end
    end
  endtask

  task automatic test_word_store;
    int stable_bad = 0;
    int dones = 0;
    issue(1'b1, 3'b100, 1'b0, 32'h8, 32'h12345678);
    for (int i = 0; i < 6; i++) begin
      if (ADR !== 32'h8 || DATA !== 32'h12345678 || WR_nRD !== 1'b1 || bhw !== 3'b100 ||
          cpu_done !== 1'b0 || (i > 0 && request !== 1'b0)) stable_bad++;
      @(negedge CLK);
    end
    send = 1'b1; DATAOUT = 32'hCAFEF00D;
    @(negedge CLK);
    send = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0 || ADR !== 32'h8 || DATA !== 32'h12345678) begin
      errors++; $display("FAIL ws_done: got done=%b rdata=%h adr=%h data=%h expected 1 0 8 12345678",
                         cpu_done, cpu_rdata, ADR, DATA);
    end
    for (int i = 0; i < 4; i++) begin
      if (cpu_done === 1'b1) dones++;
      @(negedge CLK);
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++; $display("FAIL ws_stable: got %0d unstable cycles expected 0", stable_bad);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL ws_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_stray_send;
    int bad = 0;
    send = 1'b1; DATAOUT = 32'h55;
    repeat (3) begin
      @(negedge CLK);
      if (cpu_busy !== 1'b0 || cpu_done !== 1'b0 || request !== 1'b0) bad++;
    end
    send = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stray_send: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_bhw = 3'b100; cpu_sgn = 1'b0; cpu_adr = 32'h40;
    @(negedge CLK);
    send = 1'b1; DATAOUT = 32'h1;
    @(negedge CLK);
    send = 1'b0;
    checks++;
    if (cpu_done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got %b expected 1", cpu_done);
    end
    @(negedge CLK);
    checks++;
    if (cpu_busy !== 1'b0 || request !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b req=%b expected 0 0", cpu_busy, request);
    end
    @(negedge CLK);
    cpu_req = 1'b0;
    checks++;
    if (request !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got req=%b expected 1", request);
    end
    send = 1'b1; DATAOUT = 32'h2;
    @(negedge CLK);
    send = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'h2) begin
      errors++; $display("FAIL b2b_second: got done=%b rdata=%h expected 1 2", cpu_done, cpu_rdata);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int late_done = 0;
    issue(1'b1, 3'b100, 1'b0, 32'hC, 32'hA5A5A5A5);
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    #1;
    checks++;
    if ({request, cpu_busy, cpu_done, cpu_err, bhw, WR_nRD, ADR, DATA, cpu_rdata} !== '0) begin
      errors++; $display("FAIL rst_mid: got req=%b busy=%b bhw=%b wr=%b adr=%h data=%h expected all zero",
                         request, cpu_busy, bhw, WR_nRD, ADR, DATA);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    send = 1'b1; DATAOUT = 32'h99;
    @(negedge CLK);
    send = 1'b0;
    repeat (3) begin
      if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) late_done++;
      @(negedge CLK);
    end
    checks++;
    if (late_done !== 0) begin
      errors++; $display("FAIL rst_late_send: got %0d active cycles expected 0", late_done);
    end
  endtask

`ifdef MEM_INITIATOR_TIMEOUT_EN
  task automatic test_timeout;
    int waits = 0;
    int dones = 0;
    bit seen = 1'b0;
    issue(1'b0, 3'b100, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (cpu_err === 1'b1) seen = 1'b1;
      else waits++;
    end
    checks++;
    if (!seen || waits !== 4) begin
      errors++; $display("FAIL timeout: got seen=%b wait_cycles=%0d expected 1 4", seen, waits);
    end
    @(negedge CLK);
    send = 1'b1;
    @(negedge CLK);
    send = 1'b0;
    repeat (3) begin
      if (cpu_done === 1'b1) dones++;
      @(negedge CLK);
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL timeout_late_send: got %0d dones expected 0", dones);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_load_extend();
    test_illegal();
    test_word_store();
    test_stray_send();
    test_back_to_back();
`ifdef MEM_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of WAIT cycles without send before abort; legal range 1..255.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 cpu_req  input  1  CPU access strobe; sampled only in IDLE.
REQ-005 cpu_wr  input  1  1 = store, 0 = load.
REQ-006 cpu_bhw  input  3  size, one-hot: 001 byte, 010 half, 100 word.
REQ-007 cpu_sgn  input  1  1 = sign-extend load data, 0 = zero-extend.
REQ-008 cpu_adr  input  32  byte address.
REQ-009 cpu_wdata  input  32  store data, right-justified.
REQ-010 cpu_rdata  output  32  extended load data; valid while cpu_done=1.
REQ-011 cpu_done  output  1  one-cycle completion pulse.
REQ-012 cpu_err  output  1  one-cycle pulse: misaligned, illegal size, or timeout.
REQ-013 cpu_busy  output  1  high in every state except IDLE.
REQ-014 request  output  1  memory request strobe, exactly one cycle per access.
REQ-015 bhw, WR_nRD, ADR, DATA  outputs  3/1/32/32  memory command fields, registered.
REQ-016 DATAOUT  input  32  memory read data, right-justified; valid when send=1.
REQ-017 send  input  1  memory completion pulse.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, DONE, ERR, encoded in 3 bits.
REQ-019 IDLE + cpu_req + legal access: latch cpu_bhw/cpu_wr/cpu_adr/cpu_wdata/cpu_sgn into bhw/WR_nRD/ADR/DATA and go to REQ; request high the following cycle.
REQ-020 Legal access: bhw one-hot; half needs ADR[0]=0; word needs ADR[1:0]=00; otherwise IDLE -> ERR with no request issued.
REQ-021 REQ lasts exactly one cycle with request=1, then WAIT (unless send seen, see REQ-023).
REQ-022 bhw, WR_nRD, ADR, DATA SHALL remain stable from REQ entry until return to IDLE.
REQ-023 send sampled in REQ or WAIT -> DONE; on the same edge, for loads, capture DATAOUT with extension (byte from bit 7, half from bit 15, word unchanged; cpu_sgn=0 zero-fills).
REQ-024 DONE: cpu_done=1 for one cycle, cpu_rdata valid (stores return 0), then IDLE.
REQ-025 ERR: cpu_err=1 for one cycle, then IDLE; cpu_rdata=0.
REQ-026 send in IDLE, DONE or ERR SHALL be ignored (late or stray responses dropped).
REQ-027 Best-case latency: cpu_req edge N -> request at N+1 -> send at N+2 -> cpu_done at N+3.
REQ-028 cpu_req held high across DONE SHALL start a new access only on the edge after return to IDLE.

Reset
REQ-029 nRST low SHALL immediately force IDLE, all outputs 0 and timeout counter 0, including mid-access; a memory response arriving after reset release is ignored per REQ-026.

Configuration
REQ-030 Macro MEM_INITIATOR_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each WAIT cycle; reaching TIMEOUT without send -> ERR.
REQ-031 Macro undefined: no counter is built; WAIT persists until send or reset.

Verification
REQ-032 Word load ADR=0x10, memory send 1 cycle after request with DATAOUT=0xDEADBEEF -> request one cycle, cpu_done 3 cycles after cpu_req, cpu_rdata=0xDEADBEEF.
REQ-033 Byte load cpu_sgn=1, DATAOUT=0x00000080 -> cpu_rdata=0xFFFFFF80; same with cpu_sgn=0 -> 0x00000080.
REQ-034 Half store ADR=0x3 -> no request, cpu_err pulse one cycle after cpu_req, cpu_busy one cycle.
REQ-035 Word store ADR=0x8, DATA=0x12345678, send after 5 WAIT cycles -> ADR/DATA/WR_nRD=1/bhw=100 stable throughout, cpu_done once.
REQ-036 TIMEOUT_EN, TIMEOUT=4, send never asserted -> cpu_err pulse after 4 WAIT cycles; later send ignored, no cpu_done.
REQ-037 nRST asserted in WAIT, released, then send pulse -> all outputs 0, state IDLE, no cpu_done.
